// File: rtl/wdt_kick_ctrl_if.sv
// ---------------------------------------------------------------------------
// wdt_kick_ctrl_if
// Groups the command and status signals between the register decode / watchdog
// core side (master) and the kick controller (slave).
//
// Signals (master -> slave):
//   wdt_clk_en   counter clock-enable tick from the watchdog core
//   wr_crr       one-pclk write strobe to the counter-restart register
//   crr_wdata    CRR write data (8 bit)
//   rd_eoi       one-pclk read strobe of the end-of-interrupt register
//   wr_cr        one-pclk write strobe to the control register
//   cr_en_wdata  enable bit of the CR write data
//   err_clr      one-pclk strobe clearing key_err and win_err
//   cnt          current down-counter value
//   win_top      window threshold; a kick is legal only when cnt <= win_top
// Signals (slave -> master):
//   wdt_en       sticky watchdog enable
//   restart      restart pulse to the counter/interrupt logic
//   eoi_en       interrupt-clear pulse to the interrupt logic
//   kick_pend    accepted kick waiting for a clock-enable cycle
//   key_err      sticky: CRR written with the wrong key
//   win_err      sticky: early kick rejected
// ---------------------------------------------------------------------------
interface wdt_kick_ctrl_if #(
  parameter int WDT_CNT_WIDTH = 32
) ();

  logic                     wdt_clk_en;
  logic                     wr_crr;
  logic [7:0]               crr_wdata;
  logic                     rd_eoi;
  logic                     wr_cr;
  logic                     cr_en_wdata;
  logic                     err_clr;
  logic [WDT_CNT_WIDTH-1:0] cnt;
  logic [WDT_CNT_WIDTH-1:0] win_top;

  logic                     wdt_en;
  logic                     restart;
  logic                     eoi_en;
  logic                     kick_pend;
  logic                     key_err;
  logic                     win_err;

  // Register decode / watchdog core side.
  modport master (
    output wdt_clk_en, wr_crr, crr_wdata, rd_eoi, wr_cr, cr_en_wdata,
           err_clr, cnt, win_top,
    input  wdt_en, restart, eoi_en, kick_pend, key_err, win_err
  );

  // Kick controller side.
  modport slave (
    input  wdt_clk_en, wr_crr, crr_wdata, rd_eoi, wr_cr, cr_en_wdata,
           err_clr, cnt, win_top,
    output wdt_en, restart, eoi_en, kick_pend, key_err, win_err
  );

endinterface

// File: rtl/wdt_kick_ctrl.sv
// ---------------------------------------------------------------------------
// wdt_kick_ctrl
// Command-side initiator for the watchdog counter and interrupt generator.
// Turns register strobes into restart / eoi_en / wdt_en controls:
//   - restart writes are accepted only with the right key and, optionally,
//     only inside the window (cnt <= win_top, unsigned);
//   - wdt_en is sticky and only cleared by reset;
//   - accepted kicks and EOI reads are held pending and issued as one-pclk
//     pulses on the next wdt_clk_en cycle so the core cannot miss them.
//
// Ports:
//   pclk     block clock
//   presetn  asynchronous active-low reset
//   bus      wdt_kick_ctrl_if slave modport (strobes in, controls/flags out)
// ---------------------------------------------------------------------------
module wdt_kick_ctrl #(
  parameter int         WDT_CNT_WIDTH = 32,
  parameter logic [7:0] KICK_KEY      = 8'h76,
  parameter bit         WIN_EN        = 1'b1
) (
  input  logic              pclk,
  input  logic              presetn,
  wdt_kick_ctrl_if.slave    bus
);

  logic                     wdtEn_q,    wdtEn_d;
  logic                     kickPend_q, kickPend_d;
  logic                     eoiPend_q,  eoiPend_d;
  logic                     keyErr_q,   keyErr_d;
  logic                     winErr_q,   winErr_d;

  logic [WDT_CNT_WIDTH-1:0] cntVal;
  logic [WDT_CNT_WIDTH-1:0] winTopVal;
  logic                     kickTry;
  logic                     keyMatch;
  logic                     earlyKick;
  logic                     kickOk;
  logic                     restartFire;
  logic                     eoiFire;

  assign cntVal    = bus.cnt;
  assign winTopVal = bus.win_top;

  // Decode of the restart write. Writes while the watchdog is disabled are
  // dropped entirely; a key mismatch takes priority over the window check so
  // at most one error flag is raised per write.
  always_comb begin
    kickTry   = bus.wr_crr & wdtEn_q;
    keyMatch  = (bus.crr_wdata == KICK_KEY);
    earlyKick = WIN_EN && (cntVal > winTopVal);
    kickOk    = kickTry & keyMatch & ~earlyKick;
  end

  // Pulses are pure functions of registered pending flags and the tick, so
  // there is no combinational path from the strobes to restart/eoi_en.
  always_comb begin
    restartFire = kickPend_q & bus.wdt_clk_en;
    eoiFire     = eoiPend_q & bus.wdt_clk_en;
  end

  // Next-state logic. A pending flag clears on the cycle it fires and a new
  // request arriving in that same cycle is absorbed rather than re-arming.
  // Error flags: a new error in the err_clr cycle wins over the clear.
  always_comb begin
    wdtEn_d    = wdtEn_q | (bus.wr_cr & bus.cr_en_wdata);
    kickPend_d = restartFire ? 1'b0 : (kickPend_q | kickOk);
    eoiPend_d  = eoiFire ? 1'b0 : (eoiPend_q | bus.rd_eoi);
    keyErr_d   = (kickTry & ~keyMatch) | (keyErr_q & ~bus.err_clr);
    winErr_d   = 1'b0;
    if (WIN_EN) begin
      winErr_d = (kickTry & keyMatch & earlyKick) | (winErr_q & ~bus.err_clr);
    end
  end

  // State registers; reset drops everything, including pending commands, so
  // nothing is issued after release until a fresh strobe arrives.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wdtEn_q    <= 1'b0;
      kickPend_q <= 1'b0;
      eoiPend_q  <= 1'b0;
      keyErr_q   <= 1'b0;
      winErr_q   <= 1'b0;
    end else begin
      wdtEn_q    <= wdtEn_d;
      kickPend_q <= kickPend_d;
      eoiPend_q  <= eoiPend_d;
      keyErr_q   <= keyErr_d;
      winErr_q   <= winErr_d;
    end
  end

  // Drive the interface outputs.
  always_comb begin
    bus.wdt_en    = wdtEn_q;
    bus.restart   = restartFire;
    bus.eoi_en    = eoiFire;
    bus.kick_pend = kickPend_q;
    bus.key_err   = keyErr_q;
    bus.win_err   = winErr_q;
  end

endmodule

// File: tb/tb_wdt_kick_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wdt_kick_ctrl
// Self-checking bench for wdt_kick_ctrl. Each vector drives one cycle of
// inputs and states the outputs that must be visible during that cycle,
// packed as {wdt_en, kick_pend, restart, eoi_en, key_err, win_err}.
// ---------------------------------------------------------------------------
module tb_wdt_kick_ctrl;

  typedef struct {
    string       name;
    logic        wrCr;
    logic        crEn;
    logic        wrCrr;
    logic [7:0]  crrData;
    logic        rdEoi;
    logic        errClr;
    logic        clkEn;
    logic [31:0] cnt;
    logic [31:0] winTop;
    logic [5:0]  expOut;
  } vecT;

  typedef struct {
    string      name;
    logic [5:0] expOut;
  } expT;

  logic clock;
  logic presetn;

  vecT  vecs[$];
  expT  sbQ[$];
  int   assertCount;
  int   failCount;

  wdt_kick_ctrl_if #(.WDT_CNT_WIDTH(32)) bus ();

  wdt_kick_ctrl #(
    .WDT_CNT_WIDTH(32),
    .KICK_KEY     (8'h76),
    .WIN_EN       (1'b1)
  ) dut (
    .pclk   (clock),
    .presetn(presetn),
    .bus    (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got hang, expected completion");
    $fatal(1, "[TB] timeout");
  end

  function automatic void addVec(string n, logic wrCr, logic crEn, logic wrCrr,
                                 logic [7:0] d, logic rdEoi, logic errClr,
                                 logic clkEn, logic [31:0] cnt,
                                 logic [31:0] winTop, logic [5:0] expOut);
    vecT v;
    v.name    = n;
    v.wrCr    = wrCr;
    v.crEn    = crEn;
    v.wrCrr   = wrCrr;
    v.crrData = d;
    v.rdEoi   = rdEoi;
    v.errClr  = errClr;
    v.clkEn   = clkEn;
    v.cnt     = cnt;
    v.winTop  = winTop;
    v.expOut  = expOut;
    vecs.push_back(v);
  endfunction

  function automatic void pushExpect(string n, logic [5:0] expOut);
    expT e;
    e.name   = n;
    e.expOut = expOut;
    sbQ.push_back(e);
  endfunction

  task automatic driveInputs(logic wrCr, logic crEn, logic wrCrr, logic [7:0] d,
                             logic rdEoi, logic errClr, logic clkEn,
                             logic [31:0] cnt, logic [31:0] winTop);
    bus.wr_cr       = wrCr;
    bus.cr_en_wdata = crEn;
    bus.wr_crr      = wrCrr;
    bus.crr_wdata   = d;
    bus.rd_eoi      = rdEoi;
    bus.err_clr     = errClr;
    bus.wdt_clk_en  = clkEn;
    bus.cnt         = cnt;
    bus.win_top     = winTop;
  endtask

  // Drive one vector on the falling edge and queue its expected outputs.
  task automatic applyStimulus(vecT v);
    @(negedge clock);
    driveInputs(v.wrCr, v.crEn, v.wrCrr, v.crrData, v.rdEoi, v.errClr,
                v.clkEn, v.cnt, v.winTop);
    pushExpect(v.name, v.expOut);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic checkOutput();
    expT        e;
    logic [5:0] act;
    #1;
    act = {bus.wdt_en, bus.kick_pend, bus.restart, bus.eoi_en,
           bus.key_err, bus.win_err};
    assertCount++;
    if (sbQ.size() == 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_empty: got output %b with no expectation queued", act);
    end else begin
      e = sbQ.pop_front();
      if (act !== e.expOut) begin
        failCount++;
        $display("[TB] FAIL %s: got {en,pend,rst,eoi,kerr,werr}=%b, expected %b",
                 e.name, act, e.expOut);
      end
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    presetn     = 1'b0;
    driveInputs(0, 0, 0, 8'h00, 0, 0, 0, 32'd0, 32'd0);

    // Reset state, checked while presetn is still low.
    repeat (2) @(negedge clock);
    pushExpect("reset_state", 6'b000000);
    checkOutput();
    @(negedge clock);
    presetn = 1'b1;

    //     name              wrCr crEn wrCrr data   eoi clr clkEn cnt           winTop  exp
    addVec("idle_disabled",   0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b000000);
    addVec("kick_while_off",  0,  0,   1,   8'h76, 1,  0,  1,    32'd50,       32'd100, 6'b000000);
    addVec("eoi_while_off",   1,  1,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b000100);
    addVec("en_set",          1,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b100000);
    addVec("en_sticky",       0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b100000);
    addVec("kick_good",       0,  0,   1,   8'h76, 0,  0,  1,    32'd50,       32'd100, 6'b100000);
    addVec("restart_pulse",   0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b111000);
    addVec("restart_done",    0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b100000);
    addVec("eoi_read",        0,  0,   0,   8'h00, 1,  0,  1,    32'd50,       32'd100, 6'b100000);
    addVec("eoi_pulse",       0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b100100);
    addVec("bad_key",         0,  0,   1,   8'h55, 0,  0,  1,    32'd50,       32'd100, 6'b100000);
    addVec("key_err_set",     0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b100010);
    addVec("key_err_clr",     0,  0,   0,   8'h00, 0,  1,  1,    32'd50,       32'd100, 6'b100010);
    addVec("key_err_gone",    0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b100000);
    addVec("bad_key_clr",     0,  0,   1,   8'h55, 0,  1,  1,    32'd50,       32'd100, 6'b100000);
    addVec("err_beats_clr",   0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b100010);
    addVec("key_err_clr2",    0,  0,   0,   8'h00, 0,  1,  1,    32'd50,       32'd100, 6'b100010);
    addVec("early_kick",      0,  0,   1,   8'h76, 0,  0,  1,    32'd200,      32'd100, 6'b100000);
    addVec("win_err_set",     0,  0,   0,   8'h00, 0,  0,  1,    32'd200,      32'd100, 6'b100001);
    addVec("kick_at_top",     0,  0,   1,   8'h76, 0,  0,  1,    32'd100,      32'd100, 6'b100001);
    addVec("restart_at_top",  0,  0,   0,   8'h00, 0,  0,  1,    32'd100,      32'd100, 6'b111001);
    addVec("win_err_clr",     0,  0,   0,   8'h00, 0,  1,  1,    32'd100,      32'd100, 6'b100001);
    addVec("win_err_gone",    0,  0,   0,   8'h00, 0,  0,  1,    32'd100,      32'd100, 6'b100000);
    addVec("kick_no_tick",    0,  0,   1,   8'h76, 0,  0,  0,    32'd50,       32'd100, 6'b100000);
    addVec("kick_coalesce",   0,  0,   1,   8'h76, 0,  0,  0,    32'd50,       32'd100, 6'b110000);
    addVec("kick_and_eoi",    0,  0,   1,   8'h76, 1,  0,  0,    32'd50,       32'd100, 6'b110000);
    addVec("both_held",       0,  0,   0,   8'h00, 0,  0,  0,    32'd50,       32'd100, 6'b110000);
    addVec("both_fire",       0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b111100);
    addVec("both_done",       0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b100000);
    addVec("absorb_arm",      0,  0,   1,   8'h76, 0,  0,  0,    32'd50,       32'd100, 6'b100000);
    addVec("absorb_fire",     0,  0,   1,   8'h76, 0,  0,  1,    32'd50,       32'd100, 6'b111000);
    addVec("absorb_no_rearm", 0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b100000);
    addVec("top_plus_one",    0,  0,   1,   8'h76, 0,  0,  1,    32'd101,      32'd100, 6'b100000);
    addVec("win_err_plus1",   0,  0,   0,   8'h00, 0,  0,  1,    32'd101,      32'd100, 6'b100001);
    addVec("win_err_clr3",    0,  0,   0,   8'h00, 0,  1,  1,    32'd101,      32'd100, 6'b100001);
    addVec("win_err_gone3",   0,  0,   0,   8'h00, 0,  0,  1,    32'd101,      32'd100, 6'b100000);
    addVec("unsigned_kick",   0,  0,   1,   8'h76, 0,  0,  1,    32'h80000000, 32'd1,   6'b100000);
    addVec("unsigned_err",    0,  0,   0,   8'h00, 0,  0,  1,    32'h80000000, 32'd1,   6'b100001);
    addVec("unsigned_clr",    0,  0,   0,   8'h00, 0,  1,  1,    32'h80000000, 32'd1,   6'b100001);
    addVec("unsigned_gone",   0,  0,   0,   8'h00, 0,  0,  1,    32'd50,       32'd100, 6'b100000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Tick every 8 cycles, three good kicks between ticks: one restart on the
    // tick, kick_pend high from the cycle after the first kick until then.
    for (int c = 0; c < 16; c++) begin
      logic kick;
      logic tick;
      logic pend;
      logic fire;
      kick = (c == 1) || (c == 3) || (c == 5);
      tick = (c % 8) == 7;
      pend = (c >= 2) && (c <= 7);
      fire = pend && tick;
      @(negedge clock);
      driveInputs(0, 0, kick, 8'h76, 0, 0, tick, 32'd50, 32'd100);
      pushExpect($sformatf("tick8_c%0d", c), {1'b1, pend, fire, 3'b000});
      checkOutput();
    end

    // Kick left pending with the tick held low, then asynchronous reset.
    @(negedge clock);
    driveInputs(0, 0, 1, 8'h76, 0, 0, 0, 32'd50, 32'd100);
    pushExpect("rst_kick", 6'b100000);
    checkOutput();
    @(negedge clock);
    driveInputs(0, 0, 0, 8'h00, 0, 0, 0, 32'd50, 32'd100);
    pushExpect("rst_pending", 6'b110000);
    checkOutput();
    #2;
    presetn        = 1'b0;
    bus.wdt_clk_en = 1'b1;
    pushExpect("rst_async_clear", 6'b000000);
    checkOutput();
    @(negedge clock);
    presetn = 1'b1;
    pushExpect("rst_release", 6'b000000);
    checkOutput();
    @(negedge clock);
    pushExpect("rst_no_restart", 6'b000000);
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/wdt_kick_ctrl.md
Name: wdt_kick_ctrl

Overview:
Command-side initiator for the watchdog counter and interrupt generator. It turns bus-level register strobes into the `restart`, `eoi_en` and `wdt_en` controls the watchdog core consumes.
- Key-protected restart (kick) writes.
- Window check against early kicks.
- Sticky enable lock.
- Aligns every single-cycle command to `wdt_clk_en`, so the core, which only advances on clock-enable cycles, never misses a command.

Sits between the APB register decode and the watchdog counter/interrupt logic.

Parameters:
WDT_CNT_WIDTH, 32, width of counter value and window threshold
KICK_KEY, 8'h76, only CRR write data accepted as a valid kick
WIN_EN, 1, 1 = early-kick window check active; 0 = check disabled, win_err tied 0

Ports:
pclk  input  1  block clock
presetn  input  1  asynchronous active-low reset
wdt_clk_en  input  1  counter clock-enable tick from watchdog core
wr_crr  input  1  one-pclk write strobe to counter-restart register
crr_wdata  input  8  CRR write data
rd_eoi  input  1  one-pclk read strobe of end-of-interrupt register
wr_cr  input  1  one-pclk write strobe to control register
cr_en_wdata  input  1  enable bit of CR write data
err_clr  input  1  one-pclk strobe clearing key_err and win_err
cnt  input  WDT_CNT_WIDTH  current down-counter value
win_top  input  WDT_CNT_WIDTH  window threshold; kick legal only when cnt <= win_top
wdt_en  output  1  watchdog enable to counter (sticky)
restart  output  1  restart pulse to counter/interrupt logic
eoi_en  output  1  interrupt-clear pulse to interrupt logic
kick_pend  output  1  accepted kick awaiting issue
key_err  output  1  sticky: CRR written with wrong key
win_err  output  1  sticky: early kick rejected

Behaviour:
- Reset: all outputs and internal flags are 0, asynchronously on presetn low, including mid-pending. No command is issued after reset release until a new strobe arrives.
- wdt_en:
  - Set on wr_cr with cr_en_wdata=1.
  - wr_cr with cr_en_wdata=0 is ignored; only reset clears it.
- Kick acceptance, evaluated in the wr_crr cycle:
  - With wdt_en=0: wr_crr is ignored; no flags change.
  - With wdt_en=1 and crr_wdata!=KICK_KEY: key_err is set next cycle; the kick is discarded.
  - With wdt_en=1, key match, WIN_EN=1 and cnt>win_top: win_err is set next cycle; the kick is discarded.
  - Otherwise the kick is accepted and kick_pend=1 next cycle.
- Restart issue:
  - restart=1 for exactly one pclk in a cycle where kick_pend=1 and wdt_clk_en=1.
  - kick_pend clears in that same cycle's update (restart registered, kick_pend 0 afterwards).
  - Latency with wdt_clk_en constantly 1: wr_crr in cycle N, kick_pend high in cycle N+1, restart high in cycle N+1.
  - restart = kick_pend & wdt_clk_en, which is combinational from registered state.
  - Hold: kick_pend stays high until a wdt_clk_en cycle occurs.
- Coalescing:
  - Further accepted kicks while kick_pend=1 produce no extra restart.
  - An accepted kick in the same cycle restart fires is absorbed; kick_pend does not re-arm.
- EOI:
  - rd_eoi sets eoi_pend regardless of wdt_en.
  - eoi_en = eoi_pend & wdt_clk_en; eoi_pend clears when eoi_en fires.
  - Coalescing is the same as for kicks.
  - restart and eoi_en may fire in the same cycle.
- Errors:
  - key_err and win_err hold until err_clr or reset.
  - err_clr in the same cycle as a new error: the error wins (flag stays 1).
- Window compare is unsigned, full WDT_CNT_WIDTH. cnt==win_top is legal.
- All state is pclk-domain; no combinational path from wr_crr/rd_eoi to restart/eoi_en.

Test Plan:
- Reset, then wr_cr with cr_en_wdata=1, then wr_cr with cr_en_wdata=0 -> wdt_en 0 before the first write, 1 after it, and stays 1 after the second.
- wdt_en=1, wdt_clk_en=1 every cycle, wr_crr with 8'h76 and cnt<=win_top -> single restart pulse one cycle after the strobe; kick_pend low afterwards.
- wdt_clk_en pulses every 8 cycles; three key kicks between ticks -> exactly one restart, coincident with the next tick; kick_pend high until that tick.
- wr_crr with 8'h55 -> key_err=1, no restart. Then err_clr -> key_err=0. Then err_clr together with another bad write -> key_err stays 1.
- win_top=100, cnt=200, key kick -> win_err=1, no restart. Same kick with cnt=100 -> restart issued.
- Kick pending with wdt_clk_en held low, presetn asserted -> kick_pend, wdt_en and restart all 0 immediately. After release, a wdt_clk_en tick -> no restart.
